pwm_output_driver: RTL and testbench
====================================

// Module: pwm_output_driver
// PURPOSE
//  Consumes the SPI register map (output enables, PWM enables, duty cycle) and drives 16 output pins.
//  Each pin is one of three things, selected per bit by the enable registers: forced low, static high,
//  or a shared PWM waveform. Sits directly downstream of the SPI register block in the same clk domain.
//  Nominal PWM frequency is about 3 kHz at clk = 10 MHz (10 MHz / (13*256)).
// PARAMETERS
//  PRESCALE   13  clk cycles per PWM counter step; legal range 1..65535
//  CNT_W      8   PWM counter width; fixed by the 8-bit duty register, do not change
// PORTS
//  clk               in   1   system clock; all logic on rising edge
//  rst_n             in   1   reset, asynchronous, active-low
//  en_reg_out_7_0    in   8   per-pin output enable, pins 7..0 (1 = pin active)
//  en_reg_out_15_8   in   8   per-pin output enable, pins 15..8
//  en_reg_pwm_7_0    in   8   per-pin PWM select, pins 7..0 (1 = PWM, 0 = static high)
//  en_reg_pwm_15_8   in   8   per-pin PWM select, pins 15..8
//  pwm_duty_cycle    in   8   shared duty; high for duty/256 of the period, 0xFF = 100 %
//  out               out  16  registered pin drive; out[15:8] / out[7:0]
//  period_start      out  1   one-clk pulse when PWM counter wraps 0xFF->0x00
// BEHAVIOUR
//  - Reset: prescaler = 0, pwm_cnt = 0x00, out = 16'h0000, period_start = 0, duty shadow = 0x00.
//  - Reset is asynchronous and may assert mid-period. All state clears at once.
//    After rst_n deasserts, counting restarts from prescaler = 0, pwm_cnt = 0.
//  - Prescaler: counts 0..PRESCALE-1, then returns to 0; tick = (prescaler == PRESCALE-1).
//    With PRESCALE = 1, tick is constantly 1.
//  - pwm_cnt: CNT_W-bit, increments on tick only, wraps 0xFF->0x00 with no stall.
//    PWM period = 256*PRESCALE clk.
//  - period_start: asserted for the single clk in which tick=1 and pwm_cnt=0xFF.
//  - Waveform: pwm_sig = (duty_eff == 8'hFF) ? 1 : (pwm_cnt < duty_eff). Unsigned 8-bit compare.
//    duty 0x00 -> constant 0. duty 0x80 -> high for pwm_cnt 0..127, i.e. 128*PRESCALE clk per period.
//  - Per-pin select, with en = {en_reg_out_15_8, en_reg_out_7_0}, pm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
//      en[i]=0           -> out[i]=0 (pm[i] ignored)
//      en[i]=1, pm[i]=0  -> out[i]=1
//      en[i]=1, pm[i]=1  -> out[i]=pwm_sig
//  - Latency: out is registered, so it reflects the register inputs and pwm_cnt one clk later.
//    An enable change is visible on out exactly 1 clk after the input changes, mid-period or not.
//  - The register inputs are already synchronous to clk; no synchronizers here.
//  - The counter never stops: it runs regardless of enables, so all PWM pins share phase.
// CONFIGURATION
//  DUTY_SHADOW_EN defined:
//    - duty_eff comes from a shadow register.
//    - The shadow loads pwm_duty_cycle only in the period_start cycle.
//      The new duty therefore takes effect at pwm_cnt = 0x00 of the next period.
//    - Result: glitch-free, never a partial period. Shadow resets to 0x00, so output is low until the first wrap.
//  DUTY_SHADOW_EN undefined:
//    - duty_eff = pwm_duty_cycle directly, so a duty change can alter the current period.
//    - No shadow flop is built.
// TESTING (PRESCALE=13)
//  1. en=0x0001, pm=0x0001, duty=0x80 -> out[0] high 1664 clk / low 1664 clk, period 3328 clk; out[15:1]=0.
//  2. en=0xFFFF, pm=0x0000, any duty -> out=16'hFFFF 1 clk after the write.
//     Then en=0x00FF -> out=16'h00FF 1 clk later.
//  3. en=pm=0xFFFF, duty=0x00 -> out=0 for a full 3328 clk.
//     duty=0xFF -> out=0xFFFF for a full 3328 clk (no 1-step dip).
//  4. en=0xFFFF, pm=0xAAAA, duty=0x40 -> even pins constant 1.
//     Odd pins high 832 clk per 3328; period_start pulses every 3328 clk.
//  5. Assert rst_n low at pwm_cnt=0x57 -> out=0 immediately.
//     After release with en=pm=0x0001, duty=0x80 -> first rising out[0] 1 clk after release; period_start first at clk 3328.
//  6. With DUTY_SHADOW_EN: change duty 0x80->0x20 at pwm_cnt=0x10.
//     -> current period keeps 1664 clk high; next period 416 clk high.
//     Without the macro: the change is visible in the same period.

Source files
------------

// File: rtl/pwm_output_driver.sv
// 16-pin output driver: each pin forced low, static high, or a shared PWM waveform.
// Optional macro DUTY_SHADOW_EN: duty is sampled only at the period wrap (glitch-free updates).
`timescale 1ns/1ps
module pwm_output_driver #(
    parameter int PRESCALE = 13,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int               PS_W    = 16;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  prescaler_q, prescaler_d;
    logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      out_q, out_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] duty_eff;
    logic             pwm_sig;
    logic [15:0]      en;
    logic [15:0]      pm;

    // Full-scale duty is treated as 100 %, otherwise the last counter step would dip low.
    function automatic logic pwm_level(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] duty);
        if (duty == {CNT_W{1'b1}}) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

    assign en   = {en_reg_out_15_8, en_reg_out_7_0};
    assign pm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick = (prescaler_q == PS_LAST);
    assign wrap = tick && (pwm_cnt_q == {CNT_W{1'b1}});

`ifdef DUTY_SHADOW_EN
    logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;

    always_comb begin
        duty_shadow_d = duty_shadow_q;
        if (wrap) begin
            duty_shadow_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_q <= '0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
        end
    end

    assign duty_eff = duty_shadow_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    assign pwm_sig = pwm_level(pwm_cnt_q, duty_eff);

    always_comb begin
        prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        period_start_d = wrap;
        out_d          = (en & ~pm) | (en & pm & {16{pwm_sig}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q    <= '0;
            pwm_cnt_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_driver.sv
// Directed scoreboard bench for pwm_output_driver (PRESCALE = 13, period 3328 clk).
`timescale 1ns/1ps
module tb_pwm_output_driver;

    localparam int PERIOD = 3328;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  e_lo, e_hi, p_lo, p_hi, duty;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_output_driver #(.PRESCALE(13), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (e_lo),
        .en_reg_out_15_8 (e_hi),
        .en_reg_pwm_7_0  (p_lo),
        .en_reg_pwm_15_8 (p_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hi[16];
    int          ps_n;
    int          ps_pos;
    int          win_len;
    logic [15:0] first_out;

`ifdef DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    function automatic void push_exp(input string tag, input int v);
        sb.push_back('{tag, v});
    endfunction

    task automatic check(input int obs);
        exp_t e;
        if (sb.size() == 0) e = '{"sb_empty", -1};
        else                e = sb.pop_front();
        n_cmp++;
        assert (obs === e.exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic drive(input logic [15:0] en, input logic [15:0] pm, input logic [7:0] d);
        {e_hi, e_lo} = en;
        {p_hi, p_lo} = pm;
        duty = d;
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_window();
        for (int b = 0; b < 16; b++) hi[b] = 0;
        ps_n    = 0;
        ps_pos  = 0;
        win_len = 0;
    endtask

    task automatic run_window(input int n);
        for (int i = 0; i < n; i++) begin
            tick1();
            win_len++;
            if (win_len == 1) first_out = out;
            for (int b = 0; b < 16; b++) hi[b] += int'(out[b]);
            if (period_start) begin
                if (ps_n == 0) ps_pos = win_len;
                ps_n++;
            end
        end
    endtask

    task automatic wait_ps(input string tag);
        bit found;
        found = 1'b0;
        push_exp(tag, 1);
        for (int i = 0; i < 4000 && !found; i++) begin
            tick1();
            if (period_start) found = 1'b1;
        end
        check(int'(found));
    endtask

    // Release reset with en=pm=0x0001, duty=0x80 and check the first full period.
    task automatic release_and_measure(input string pfx);
        int others;
        drive(16'h0001, 16'h0001, 8'h80);
        #4 rst_n = 1'b1;
        push_exp({pfx, "_rise1"}, SHADOW ? 0 : 1);
        push_exp({pfx, "_hi0"}, SHADOW ? 0 : 1664);
        push_exp({pfx, "_other_hi"}, 0);
        push_exp({pfx, "_ps_pos"}, PERIOD);
        push_exp({pfx, "_ps_n"}, 1);
        clear_window();
        run_window(PERIOD);
        others = 0;
        for (int b = 1; b < 16; b++) others += hi[b];
        check(int'(first_out));
        check(hi[0]);
        check(others);
        check(ps_pos);
        check(ps_n);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_bits;
        int sum;

        rst_n = 1'b0;
        drive(16'h0001, 16'h0001, 8'h80);
        repeat (3) tick1();
        push_exp("rst_out", 0);
        push_exp("rst_ps", 0);
        check(int'(out));
        check(int'(period_start));

        release_and_measure("t1");

        // Static-high pins and a mid-period enable change.
        drive(16'hFFFF, 16'h0000, 8'h37);
        push_exp("t2_all_high", 32'hFFFF);
        tick1();
        check(int'(out));
        drive(16'h00FF, 16'h0000, 8'h37);
        push_exp("t2_low_byte", 32'h00FF);
        tick1();
        check(int'(out));

        // Duty extremes on all PWM pins.
        drive(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps("t3a_ps");
        push_exp("t3a_sum_hi", 0);
        clear_window();
        run_window(PERIOD);
        sum = 0;
        for (int b = 0; b < 16; b++) sum += hi[b];
        check(sum);

        drive(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps("t3b_ps");
        push_exp("t3b_bits_not_full", 0);
        push_exp("t3b_hi15", PERIOD);
        clear_window();
        run_window(PERIOD);
        bad_bits = 0;
        for (int b = 0; b < 16; b++) if (hi[b] != PERIOD) bad_bits++;
        check(bad_bits);
        check(hi[15]);

        // Mixed static/PWM pins at quarter duty.
        drive(16'hFFFF, 16'hAAAA, 8'h40);
        wait_ps("t4_ps");
        push_exp("t4_hi0", PERIOD);
        push_exp("t4_hi1", 832);
        push_exp("t4_bad_bits", 0);
        push_exp("t4_ps_n", 1);
        push_exp("t4_ps_pos", PERIOD);
        clear_window();
        run_window(PERIOD);
        bad_bits = 0;
        for (int b = 0; b < 16; b++)
            if (hi[b] != ((b % 2 == 0) ? PERIOD : 832)) bad_bits++;
        check(hi[0]);
        check(hi[1]);
        check(bad_bits);
        check(ps_n);
        check(ps_pos);

        // Asynchronous reset at pwm_cnt = 0x57, then restart.
        rst_n = 1'b0;
        #2;
        drive(16'h0001, 16'h0001, 8'h80);
        #4 rst_n = 1'b1;
        repeat (8'h57 * 13 + 5) tick1();
        #2 rst_n = 1'b0;
        #1;
        push_exp("t5_out_async", 0);
        push_exp("t5_ps_async", 0);
        check(int'(out));
        check(int'(period_start));
        release_and_measure("t5");

        // Duty change 0x80 -> 0x20 at pwm_cnt = 0x10.
        drive(16'h0001, 16'h0001, 8'h80);
        wait_ps("t6_ps");
        push_exp("t6_cur_hi0", SHADOW ? 1664 : 416);
        push_exp("t6_next_hi0", 416);
        clear_window();
        run_window(16 * 13);
        drive(16'h0001, 16'h0001, 8'h20);
        run_window(PERIOD - 16 * 13);
        check(hi[0]);
        clear_window();
        run_window(PERIOD);
        check(hi[0]);

        push_exp("sb_drained", 0);
        check(sb.size() - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
